fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard-detection unit for the ARM pipeline. It keeps its own shadow pipeline of destination-register records for the stages after decode. Each cycle it chooses a forwarding source for every decode-stage operand. It raises a stall for load-use hazards, and for every RAW hazard when forwarding is disabled. It sits beside the ID stage and drives the operand muxes in EXE and the freeze inputs of the IF/ID registers.

---
 rtl/fwd_hazard_unit.sv | 99 +++++++++
 tb/tb_fwd_hazard_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-detection unit that sits beside the ID stage.
// A shadow pipeline of destination records for the stages after decode
// drives the operand-forwarding selects and the load-use / RAW stall.
module fwd_hazard_unit #(
  parameter int REG_W   = 4,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH + 1),
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_forwarding,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_read,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] sel_src,
  output logic                     hazard_stall,
  output logic [CNT_W-1:0]         stall_count
);

  // Shadow records, stage 1 (EXE) through stage DEPTH (WB)
  logic [REG_W-1:0] st_dest [1:DEPTH];
  logic [DEPTH:1]   st_wb;
  logic [DEPTH:1]   st_mr;

  logic [SEL_W-1:0]   nearest [NUM_SRC];
  logic [NUM_SRC-1:0] load_use;
  logic [NUM_SRC-1:0] raw_hazard;
  logic               accept;

  // Nearest matching stage per operand; scanning from the oldest stage lets the youngest writer win
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nearest[i] = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (id_valid && id_src_used[i] && st_wb[k] &&
            (st_dest[k] == id_src[i*REG_W +: REG_W])) begin
          nearest[i] = SEL_W'(k);
        end
      end
    end
  end

  // Classify each operand: load still in EXE, or any RAW that WB cannot cover through the register file
  always_comb begin
    load_use   = '0;
    raw_hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      load_use[i]   = (nearest[i] == SEL_W'(1)) && st_mr[1];
      raw_hazard[i] = (nearest[i] != {SEL_W{1'b0}}) && (nearest[i] != SEL_W'(DEPTH));
    end
  end

  // Forwarding selects and stall; a load-use operand falls back to the register file while stalled
  always_comb begin
    sel_src      = '0;
    hazard_stall = enable_forwarding ? (|load_use) : (|raw_hazard);
    if (enable_forwarding) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        sel_src[i*SEL_W +: SEL_W] = load_use[i] ? {SEL_W{1'b0}} : nearest[i];
      end
    end
  end

  // A stalled, flushed or empty ID slot enters the shadow pipeline as a bubble
  always_comb begin
    accept = id_valid && !hazard_stall && !flush;
  end

  // Advance the shadow pipeline and count stall cycles with saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        st_dest[k] <= '0;
      end
      st_wb       <= '0;
      st_mr       <= '0;
      stall_count <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        st_dest[k] <= st_dest[k-1];
        st_wb[k]   <= st_wb[k-1];
        st_mr[k]   <= st_mr[k-1];
      end
      st_dest[1] <= id_dest;
      st_wb[1]   <= accept && id_wb_en;
      st_mr[1]   <= accept && id_mem_read;
      if (hazard_stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_fwd_hazard_unit;

  localparam int REG_W   = 4;
  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 3;
  localparam int SEL_W   = 2;

  typedef struct {
    logic [REG_W-1:0] dest;
    bit               wb;
    bit               mr;
  } rec_t;

  logic                     clk;
  logic                     rst;
  logic                     enable_forwarding;
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_dest;
  logic                     id_wb_en;
  logic                     id_mem_read;
  logic                     flush;
  logic [NUM_SRC*SEL_W-1:0] sel_src;
  logic                     hazard_stall;
  logic [15:0]              stall_count;
  logic [NUM_SRC*SEL_W-1:0] sel_src_b;
  logic                     hazard_stall_b;
  logic [1:0]               stall_count_b;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable_forwarding(enable_forwarding), .id_valid(id_valid),
    .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .flush(flush), .sel_src(sel_src),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .enable_forwarding(enable_forwarding), .id_valid(id_valid),
    .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .flush(flush), .sel_src(sel_src_b),
    .hazard_stall(hazard_stall_b), .stall_count(stall_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [SEL_W-1:0] get_sel(input int op);
    return sel_src[op*SEL_W +: SEL_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    enable_forwarding = 1'b1;
    id_valid          = 1'b0;
    id_src            = '0;
    id_src_used       = '0;
    id_dest           = '0;
    id_wb_en          = 1'b0;
    id_mem_read       = 1'b0;
    flush             = 1'b0;
  endtask

  task automatic set_src(input int op, input logic [REG_W-1:0] r);
    id_src[op*REG_W +: REG_W] = r;
  endtask

  task automatic producer(input logic [REG_W-1:0] r, input logic is_load);
    id_valid = 1'b1; id_dest = r; id_wb_en = 1'b1; id_mem_read = is_load;
    id_src_used = '0;
  endtask

  task automatic consumer(input int op, input logic [REG_W-1:0] r);
    id_valid = 1'b1; id_dest = '0; id_wb_en = 1'b0; id_mem_read = 1'b0;
    id_src = '0; set_src(op, r); id_src_used = '0; id_src_used[op] = 1'b1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable_forwarding = 1'b1; id_valid = 1'b1; id_src = 12'h111; id_src_used = 3'b111;
    id_dest = 4'h1; id_wb_en = 1'b1; id_mem_read = 1'b1; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (sel_src !== '0) begin errors++; $display("[TB] FAIL reset_sel: got %0h expected 0", sel_src); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", hazard_stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_basic_forward();
    logic [SEL_W-1:0] exp_seq [4];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    producer(4'd1, 1'b0);
    tick();
    consumer(0, 4'd1);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (get_sel(0) !== exp_seq[c]) begin errors++; $display("[TB] FAIL basic_sel_cycle%0d: got %0d expected %0d", c, get_sel(0), exp_seq[c]); end
      checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL basic_stall_cycle%0d: got %0b expected 0", c, hazard_stall); end
      tick();
    end
  endtask

  task automatic test_priority();
    do_reset();
    producer(4'd2, 1'b0);
    tick();
    tick();
    consumer(1, 4'd2);
    #1;
    checks++; if (sel_src !== 6'b00_01_00) begin errors++; $display("[TB] FAIL priority_sel: got %0h expected %0h", sel_src, 6'b00_01_00); end
    set_src(0, 4'd2); id_src_used = 3'b011;
    #1;
    checks++; if (sel_src !== 6'b00_01_01) begin errors++; $display("[TB] FAIL same_reg_sel: got %0h expected %0h", sel_src, 6'b00_01_01); end
    do_reset();
    id_valid = 1'b1; id_dest = 4'd5; id_wb_en = 1'b0;
    tick();
    consumer(2, 4'd5);
    #1;
    checks++; if (sel_src !== '0 || hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL bubble_no_match: got sel %0h stall %0b expected sel 0 stall 0", sel_src, hazard_stall); end
  endtask

  task automatic test_load_use();
    do_reset();
    producer(4'd3, 1'b1);
    tick();
    consumer(0, 4'd3);
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL loaduse_stall: got %0b expected 1", hazard_stall); end
    checks++; if (get_sel(0) !== 2'd0) begin errors++; $display("[TB] FAIL loaduse_sel: got %0d expected 0", get_sel(0)); end
    tick();
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_release: got %0b expected 0", hazard_stall); end
    checks++; if (get_sel(0) !== 2'd2) begin errors++; $display("[TB] FAIL loaduse_sel_after: got %0d expected 2", get_sel(0)); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("[TB] FAIL loaduse_count: got %0d expected 1", stall_count); end
  endtask

  task automatic test_no_forwarding();
    logic exp_stall [3];
    exp_stall = '{1'b1, 1'b1, 1'b0};
    do_reset();
    enable_forwarding = 1'b0;
    producer(4'd4, 1'b0);
    tick();
    consumer(0, 4'd4);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (hazard_stall !== exp_stall[c]) begin errors++; $display("[TB] FAIL nofwd_stall_cycle%0d: got %0b expected %0b", c, hazard_stall, exp_stall[c]); end
      checks++; if (sel_src !== '0) begin errors++; $display("[TB] FAIL nofwd_sel_cycle%0d: got %0h expected 0", c, sel_src); end
      if (c < 2) tick();
    end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("[TB] FAIL nofwd_count: got %0d expected 2", stall_count); end
  endtask

  task automatic test_unused_and_flush();
    do_reset();
    producer(4'd6, 1'b0);
    tick();
    consumer(0, 4'd6);
    id_src_used = '0;
    #1;
    checks++; if (sel_src !== '0 || hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL unused_operand: got sel %0h stall %0b expected sel 0 stall 0", sel_src, hazard_stall); end
    do_reset();
    producer(4'd7, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    consumer(0, 4'd7);
    #1;
    checks++; if (get_sel(0) !== 2'd0) begin errors++; $display("[TB] FAIL flushed_producer: got %0d expected 0", get_sel(0)); end
    do_reset();
    producer(4'd8, 1'b1);
    tick();
    consumer(0, 4'd8);
    flush = 1'b1;
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_keeps_stall: got %0b expected 1", hazard_stall); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    producer(4'd3, 1'b1);
    tick();
    consumer(1, 4'd3);
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL midstall_pre: got %0b expected 1", hazard_stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL midstall_stall: got %0b expected 0", hazard_stall); end
    checks++; if (stall_count !== 16'd0 || stall_count_b !== 2'd0) begin errors++; $display("[TB] FAIL midstall_count: got %0d/%0d expected 0/0", stall_count, stall_count_b); end
  endtask

  task automatic test_saturation();
    logic pat [8];
    pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    enable_forwarding = 1'b0;
    id_valid = 1'b1; id_dest = 4'd9; id_wb_en = 1'b1; id_mem_read = 1'b0;
    id_src = '0; set_src(0, 4'd9); id_src_used = 3'b001;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (hazard_stall !== pat[c]) begin errors++; $display("[TB] FAIL sat_stall_cycle%0d: got %0b expected %0b", c, hazard_stall, pat[c]); end
      tick();
    end
    checks++; if (stall_count !== 16'd5) begin errors++; $display("[TB] FAIL sat_count_wide: got %0d expected 5", stall_count); end
    checks++; if (stall_count_b !== 2'd3) begin errors++; $display("[TB] FAIL sat_count_narrow: got %0d expected 3", stall_count_b); end
  endtask

  task automatic test_random();
    rec_t                     mpipe [$];
    rec_t                     bub;
    rec_t                     r;
    int                       cnt;
    int                       young;
    bit                       exp_stall;
    logic [NUM_SRC*SEL_W-1:0] exp_sel;
    bub.dest = '0; bub.wb = 1'b0; bub.mr = 1'b0;
    do_reset();
    mpipe = {};
    for (int k = 0; k < DEPTH; k++) mpipe.push_back(bub);
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (c % 40 == 0) enable_forwarding = ($urandom_range(0, 2) != 0);
      id_valid = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NUM_SRC; i++) set_src(i, REG_W'($urandom_range(0, 3)));
      id_src_used = NUM_SRC'($urandom_range(0, 7));
      id_dest     = REG_W'($urandom_range(0, 3));
      id_wb_en    = ($urandom_range(0, 3) != 0);
      id_mem_read = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      #1;
      exp_stall = 1'b0;
      exp_sel   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        young = -1;
        if (id_valid && id_src_used[i]) begin
          for (int k = 0; k < DEPTH; k++) begin
            if (young < 0 && mpipe[k].wb && mpipe[k].dest == id_src[i*REG_W +: REG_W]) young = k;
          end
        end
        if (young >= 0) begin
          if (enable_forwarding) begin
            if (young == 0 && mpipe[0].mr) exp_stall = 1'b1;
            else exp_sel[i*SEL_W +: SEL_W] = SEL_W'(young + 1);
          end else if (young < DEPTH - 1) begin
            exp_stall = 1'b1;
          end
        end
      end
      checks++; if (sel_src !== exp_sel) begin errors++; $display("[TB] FAIL rand_sel_cycle%0d: got %0h expected %0h", c, sel_src, exp_sel); end
      checks++; if (hazard_stall !== exp_stall) begin errors++; $display("[TB] FAIL rand_stall_cycle%0d: got %0b expected %0b", c, hazard_stall, exp_stall); end
      checks++; if (stall_count !== 16'(cnt)) begin errors++; $display("[TB] FAIL rand_count_cycle%0d: got %0d expected %0d", c, stall_count, cnt); end
      checks++; if (stall_count_b !== 2'((cnt > 3) ? 3 : cnt)) begin errors++; $display("[TB] FAIL rand_count_narrow_cycle%0d: got %0d expected %0d", c, stall_count_b, (cnt > 3) ? 3 : cnt); end
      if (rst) begin
        mpipe = {};
        for (int k = 0; k < DEPTH; k++) mpipe.push_back(bub);
        cnt = 0;
      end else begin
        if (exp_stall) cnt++;
        r.dest = id_dest;
        r.wb   = id_valid && !flush && !exp_stall && id_wb_en;
        r.mr   = id_valid && !flush && !exp_stall && id_mem_read;
        mpipe.push_front(r);
        void'(mpipe.pop_back());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    $display("[TB] starting fwd_hazard_unit tests");
    test_reset();
    test_basic_forward();
    test_priority();
    test_load_use();
    test_no_forwarding();
    test_unused_and_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
